// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage ALU plus EX/MEM pipeline register with stall,
// flush and optional overflow trap that squashes downstream side effects.
`default_nettype none

module alu_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              trap_en,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              ovf_exc
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam int         MSB   = DATA_W - 1;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_trap;
  logic              w_slt;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic [DATA_W-1:0] r_store;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_ovf_exc;

  assign w_sum  = src_a + src_b;
  assign w_diff = src_a - src_b;
  // Signed compare rather than the difference sign bit so SLT survives overflow.
  assign w_slt  = $signed(src_a) < $signed(src_b);

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (alu_ctrl)
      C_AND: w_result = src_a & src_b;
      C_OR:  w_result = src_a | src_b;
      C_ADD: begin
        w_result = w_sum;
        w_ovf    = (src_a[MSB] == src_b[MSB]) && (w_sum[MSB] != src_a[MSB]);
      end
      C_SUB: begin
        w_result = w_diff;
        w_ovf    = (src_a[MSB] != src_b[MSB]) && (w_diff[MSB] != src_a[MSB]);
      end
      C_SLT: w_result = {{(DATA_W-1){1'b0}}, w_slt};
      C_NOR: w_result = ~(src_a | src_b);
      default: ;
    endcase
  end

  assign w_trap = in_valid & trap_en & w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_store     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ovf_exc   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_store     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ovf_exc   <= 1'b0;
    end else if (!stall) begin
      // A trapped instruction stays valid but loses all architectural effects.
      r_valid     <= in_valid;
      r_result    <= w_result;
      r_zero      <= (w_result == '0);
      r_store     <= store_data_in;
      r_rd        <= rd_in;
      r_reg_write <= in_valid & ~w_trap & reg_write_in;
      r_mem_read  <= in_valid & ~w_trap & mem_read_in;
      r_mem_write <= in_valid & ~w_trap & mem_write_in;
      r_ovf_exc   <= w_trap;
    end
  end

  assign out_valid      = r_valid;
  assign alu_result     = r_result;
  assign zero           = r_zero;
  assign store_data_out = r_store;
  assign rd_out         = r_rd;
  assign reg_write_out  = r_reg_write;
  assign mem_read_out   = r_mem_read;
  assign mem_write_out  = r_mem_write;
  assign ovf_exc        = r_ovf_exc;

endmodule

`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: scoreboard bench for the execute stage; expected EX/MEM
// contents are queued when an instruction is driven and compared one edge later.
`default_nettype none

module tb_alu_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic        z;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ovf;
  } out_t;

  localparam out_t BUBBLE = '{v: 1'b0, res: 32'h0, z: 1'b1, sd: 32'h0, rd: 5'h0,
                              rw: 1'b0, mr: 1'b0, mw: 1'b0, ovf: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] src_a = '0, src_b = '0, store_data_in = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic        trap_en = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        out_valid, zero, reg_write_out, mem_read_out, mem_write_out, ovf_exc;
  logic [31:0] alu_result, store_data_out;
  logic [4:0]  rd_out;

  int   n_checks = 0;
  int   n_pass   = 0;
  out_t sb_q[$];
  out_t exp_o;
  out_t act_o;

  always #5 clk = ~clk;

  alu_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .store_data_in(store_data_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .trap_en(trap_en), .stall(stall), .flush(flush), .out_valid(out_valid),
    .alu_result(alu_result), .zero(zero), .store_data_out(store_data_out),
    .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .ovf_exc(ovf_exc)
  );

  assign act_o = '{v: out_valid, res: alu_result, z: zero, sd: store_data_out, rd: rd_out,
                   rw: reg_write_out, mr: mem_read_out, mw: mem_write_out, ovf: ovf_exc};

  // Reference model using 64-bit signed arithmetic for overflow detection.
  function automatic out_t model(logic iv, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] sd, logic [4:0] rd, logic rw, logic mr,
                                 logic mw, logic te);
    longint sa, sb, s;
    logic [31:0] r;
    logic o, trap;
    out_t e;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'h0;
    o = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'h0;
    endcase
    trap = iv & te & o;
    e = '{v: iv, res: r, z: (r == 32'h0), sd: sd, rd: rd,
          rw: iv & ~trap & rw, mr: iv & ~trap & mr, mw: iv & ~trap & mw, ovf: trap};
    return e;
  endfunction

  task automatic drive(logic iv, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                       logic [31:0] sd, logic [4:0] rd, logic rw, logic mr, logic mw,
                       logic te);
    in_valid = iv; alu_ctrl = c; src_a = a; src_b = b; store_data_in = sd;
    rd_in = rd; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; trap_en = te;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (act_o !== BUBBLE) $display("FAIL reset_init: got %h want %h", act_o, BUBBLE);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 4'b0010, 32'd5, 32'd7, 32'h0, 5'd3, 1, 0, 0, 0);
    sb_q.push_back(model(1, 4'b0010, 32'd5, 32'd7, 32'h0, 5'd3, 1, 0, 0, 0));
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    n_checks++;
    if (act_o !== exp_o || alu_result !== 32'd12 || rd_out !== 5'd3)
      $display("FAIL reset_add5p7: got %h want %h", act_o, exp_o);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_o !== BUBBLE) $display("FAIL reset_async: got %h want %h", act_o, BUBBLE);
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [3:0]  c_t [7] = '{4'b0110, 4'b0111, 4'b0111, 4'b1100, 4'b1111, 4'b0000, 4'b0001};
    logic [31:0] a_t [7] = '{32'h9, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h0, 32'h1234, 32'hF0F0_1234, 32'h0F00_0001};
    logic [31:0] b_t [7] = '{32'h9, 32'h3, 32'h8000_0000, 32'h0, 32'h5678, 32'h0FF0_FF00, 32'h00F0_0010};
    logic [31:0] r_t [7] = '{32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h00F0_1200, 32'h0FF0_0011};
    for (int i = 0; i < 7; i++) begin
      drive(1, c_t[i], a_t[i], b_t[i], 32'hA5A5_0000 + 32'(i), 5'(i + 8), 1, 0, 0, 1);
      sb_q.push_back(model(1, c_t[i], a_t[i], b_t[i], 32'hA5A5_0000 + 32'(i), 5'(i + 8), 1, 0, 0, 1));
      @(posedge clk); #1;
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o || alu_result !== r_t[i] || out_valid !== 1'b1)
        $display("FAIL alu_op%0d: got %h want %h (result want %h)", i, act_o, exp_o, r_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0]  c_t  [3] = '{4'b0010, 4'b0010, 4'b0110};
    logic [31:0] a_t  [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] b_t  [3] = '{32'h1, 32'h1, 32'h1};
    logic        te_t [3] = '{1'b1, 1'b0, 1'b1};
    logic        ov_t [3] = '{1'b1, 1'b0, 1'b1};
    logic        rw_t [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1, c_t[i], a_t[i], b_t[i], 32'h0, 5'd4, 1, 0, 0, te_t[i]);
      sb_q.push_back(model(1, c_t[i], a_t[i], b_t[i], 32'h0, 5'd4, 1, 0, 0, te_t[i]));
      @(posedge clk); #1;
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o || ovf_exc !== ov_t[i] || reg_write_out !== rw_t[i] || out_valid !== 1'b1)
        $display("FAIL overflow%0d: got %h want %h", i, act_o, exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    drive(1, 4'b0010, 32'd1, 32'd1, 32'h55, 5'd6, 1, 0, 0, 0);
    sb_q.push_back(model(1, 4'b0010, 32'd1, 32'd1, 32'h55, 5'd6, 1, 0, 0, 0));
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    n_checks++;
    if (act_o !== exp_o) $display("FAIL stall_load: got %h want %h", act_o, exp_o);
    else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0010, 32'd100 + 32'(i), 32'd3, 32'h66, 5'd7, 0, 1, 0, 0);
      sb_q.push_back(exp_o);
      @(posedge clk); #1;
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o || alu_result !== 32'd2)
        $display("FAIL stall_hold%0d: got %h want %h", i, act_o, exp_o);
      else n_pass++;
    end
    stall = 1'b0;
    drive(1, 4'b0010, 32'd10, 32'd20, 32'h77, 5'd9, 1, 0, 0, 0);
    sb_q.push_back(model(1, 4'b0010, 32'd10, 32'd20, 32'h77, 5'd9, 1, 0, 0, 0));
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    n_checks++;
    if (act_o !== exp_o || alu_result !== 32'd30) $display("FAIL stall_release: got %h want %h", act_o, exp_o);
    else n_pass++;
    // Trapped instruction held under stall keeps ovf_exc asserted.
    drive(1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd2, 1, 0, 0, 1);
    sb_q.push_back(model(1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd2, 1, 0, 0, 1));
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    stall = 1'b1;
    drive(1, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd1, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (act_o !== exp_o || ovf_exc !== 1'b1) $display("FAIL stall_ovf_level: got %h want %h", act_o, exp_o);
    else n_pass++;
    stall = 1'b0;
  endtask

  task automatic test_flush_back_to_back();
    logic [31:0] a, b;
    stall = 1'b1;
    flush = 1'b1;
    drive(1, 4'b0010, 32'h100, 32'h8, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0);
    sb_q.push_back(BUBBLE);
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    n_checks++;
    if (act_o !== exp_o || mem_write_out !== 1'b0) $display("FAIL flush_prio: got %h want %h", act_o, exp_o);
    else n_pass++;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      drive(1, 4'b0010, a, b, 32'(i), 5'(i), 1, 0, 0, 0);
      sb_q.push_back(model(1, 4'b0010, a, b, 32'(i), 5'(i), 1, 0, 0, 0));
      @(posedge clk); #1;
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o) $display("FAIL b2b_add%0d: got %h want %h", i, act_o, exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_bubble();
    drive(0, 4'b0010, 32'd3, 32'd4, 32'h11, 5'd5, 1, 1, 1, 1);
    sb_q.push_back(model(0, 4'b0010, 32'd3, 32'd4, 32'h11, 5'd5, 1, 1, 1, 1));
    @(posedge clk); #1;
    exp_o = sb_q.pop_front();
    n_checks++;
    if (act_o !== exp_o || out_valid !== 1'b0 || reg_write_out !== 1'b0 || mem_write_out !== 1'b0)
      $display("FAIL invalid_bubble: got %h want %h", act_o, exp_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_overflow();
    test_stall();
    test_flush_back_to_back();
    test_bubble();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute stage of the 32-bit pipeline: consumes the 4-bit ALU control code from the ALU control unit plus the ID/EX operands. It computes the ALU result and signed-overflow status, and registers the result with the pass-through memory/writeback controls into the EX/MEM pipeline register. It supports stall (hold) and flush (bubble insertion), and optionally suppresses writeback on arithmetic overflow.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, destination register address width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ID/EX slot holds a real instruction
- alu_ctrl  input  4  ALU operation code from ALU control unit
- src_a, src_b  input  DATA_W  operands (already forwarded)
- store_data_in  input  DATA_W  rt value for stores
- rd_in  input  REG_AW  destination register
- reg_write_in, mem_read_in, mem_write_in  input  1 each  downstream controls
- trap_en  input  1  enable overflow trap for add/sub
- stall  input  1  hold EX/MEM register
- flush  input  1  load bubble into EX/MEM register
- out_valid  output  1  EX/MEM slot valid
- alu_result  output  DATA_W  registered result
- zero  output  1  registered (result == 0)
- store_data_out  output  DATA_W
- rd_out  output  REG_AW
- reg_write_out, mem_read_out, mem_write_out  output  1 each
- ovf_exc  output  1  overflow exception for the instruction now in EX/MEM

## Operation
- Combinational ALU on alu_ctrl: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a−b); 0111 SLT (signed a<b → 1 else 0); 1100 NOR. Any other code → result 0, no overflow.
- Arithmetic modulo 2^DATA_W; carry-out discarded.
- Overflow detected only for ADD/SUB:
  - ADD: operands of same sign, result sign differs.
  - SUB: operands of differing sign, result sign differs from src_a.
- SLT is correct even when a−b overflows: compare signed values, not the subtraction sign bit.
- Trap condition = in_valid & trap_en & overflow.
- On trap, the slot still loads with out_valid=1, ovf_exc=1, and the computed wrapped result.
  - reg_write_out, mem_read_out and mem_write_out are forced to 0.
- When in_valid=0, a bubble loads: out_valid=0, all three controls 0, ovf_exc=0.
- Register update priority each rising edge: flush > stall > load.
  - flush: bubble (out_valid, reg_write_out, mem_read_out, mem_write_out, ovf_exc = 0; alu_result, store_data_out, rd_out = 0; zero=1).
  - stall: every output register holds its value.
  - otherwise: load as above.
- zero is computed from the ALU result in the same cycle and registered with it; it is never recomputed from a held value.

## Timing
- Latency: one clock, operands at edge N → EX/MEM outputs valid after edge N.
- Throughput: one instruction per cycle when stall=0.
- Reset (async assert, any time): all outputs 0 except zero=1. Takes effect immediately, independent of clk.
- Deassertion of rst_n is synchronous to the design; the first load occurs at the first rising edge with rst_n=1.
- Reset mid-stall: contents are lost and the bubble state is presented; no recovery of the held instruction.
- flush and stall asserted together: flush wins, bubble loaded.
- Stall with ovf_exc=1: ovf_exc stays high for every held cycle; downstream must treat it as level, not pulse.
- trap_en is sampled in the same cycle as the operands.
- All outputs are driven from flops only; no combinational input-to-output path.

## Test plan
- Reset: hold rst_n=0 asynchronously mid-cycle → all outputs 0, zero=1, before the next clk edge. Release and send ADD 5+7, rd=3, reg_write=1 → next edge alu_result=12, zero=0, rd_out=3, reg_write_out=1, out_valid=1.
- SUB 0x0000_0009−0x0000_0009 → alu_result=0, zero=1. SLT 0xFFFF_FFFB vs 3 → 1. SLT 0x7FFF_FFFF vs 0x8000_0000 → 0. NOR 0 with 0 → 0xFFFF_FFFF. Unknown code 1111 → result 0, out_valid=1.
- Overflow ADD 0x7FFF_FFFF+1:
  - trap_en=1, reg_write=1 → alu_result=0x8000_0000, ovf_exc=1, reg_write_out=0, out_valid=1.
  - Same with trap_en=0 → ovf_exc=0, reg_write_out=1.
  - SUB 0x8000_0000−1, trap_en=1 → ovf_exc=1.
- Stall: load ADD 1+1, then assert stall for 3 cycles while inputs change → outputs hold result 2 for all 3 cycles. Deassert → the new input appears after the next edge.
- Flush priority: stall=1 and flush=1 together with a valid SW (mem_write=1) → bubble, mem_write_out=0, out_valid=0. Stream back-to-back ADDs afterwards → one result per cycle, no drops.
- in_valid=0 with reg_write_in=1, mem_write_in=1 → out_valid=0 and all controls 0.
